// File: rtl/reg_arb_pkg.sv
// Shared definitions for the two-port register-bus arbiter: FSM encoding,
// port identifiers and bus widths.
package reg_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/reg_arb_hold_timer.sv
// Hold counter bounding how long a locked grant may starve the other port.
// Only instantiated when REG_ARB_HOLD_TIMEOUT_EN is defined.
module reg_arb_hold_timer #(
    parameter int MAX_HOLD = 255
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_owner_lock,
    input  logic i_other_req,
    input  logic i_owner_new,
    output logic o_ignore,
    output logic o_expire
);

    logic [7:0] count;
    logic       ignore_q;
    logic       expire_q;
    logic       honour;

    assign honour   = i_owner_lock && !ignore_q;
    assign o_ignore = ignore_q;
    assign o_expire = expire_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count    <= '0;
            ignore_q <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            // A dropped lock or a change of owner starts a fresh hold window.
            if (i_owner_new || !i_owner_lock) begin
                count    <= '0;
                ignore_q <= 1'b0;
            end else if (honour && i_other_req) begin
                if (count == 8'(MAX_HOLD - 1)) begin
                    count    <= '0;
                    ignore_q <= 1'b1;
                    expire_q <= 1'b1;
                end else begin
                    count <= count + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-port register-file arbiter (SPI host A, internal engine B) with round-robin
// and grant lock. Optional lock timeout via REG_ARB_HOLD_TIMEOUT_EN.
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 255
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_a_req,
    input  logic              i_a_wr,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    input  logic              i_a_lock,
    input  logic              i_b_req,
    input  logic              i_b_wr,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    input  logic              i_b_lock,
    output logic              o_a_ack,
    output logic [DATA_W-1:0] o_a_rdata,
    output logic              o_b_ack,
    output logic [DATA_W-1:0] o_b_rdata,
    output logic [ADDR_W-1:0] o_rf_addr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_rf_we,
    output logic              o_rf_re,
    input  logic [DATA_W-1:0] i_rf_rdata,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [1:0]        o_dbg_state
);

    arb_state_t        state, state_nxt;
    logic              last_served;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        rd_cnt;
    logic              rd_last;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    logic owner_lock, lock_ignore, lock_active;
    logic a_elig, b_elig, grant_valid, grant_port;

    // The owner is simply the last served port; only it may hold a lock.
    assign owner_lock  = (last_served == PORT_B) ? i_b_lock : i_a_lock;
    assign lock_active = owner_lock && !lock_ignore;
    assign a_elig      = i_a_req && (!lock_active || last_served == PORT_A);
    assign b_elig      = i_b_req && (!lock_active || last_served == PORT_B);
    assign grant_valid = a_elig || b_elig;
    assign grant_port  = (a_elig && b_elig) ? ~last_served : b_elig;

`ifdef REG_ARB_HOLD_TIMEOUT_EN
    logic other_req, owner_new;
    assign other_req = (last_served == PORT_B) ? i_a_req : i_b_req;
    assign owner_new = (state == IDLE) && grant_valid && (grant_port != last_served);

    reg_arb_hold_timer #(.MAX_HOLD(MAX_HOLD)) u_hold_timer (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_owner_lock (owner_lock),
        .i_other_req  (other_req),
        .i_owner_new  (owner_new),
        .o_ignore     (lock_ignore),
        .o_expire     (o_timeout)
    );
`else
    assign lock_ignore = 1'b0;
    assign o_timeout   = (MAX_HOLD < 1); // constant 0 for every legal MAX_HOLD
`endif

    assign rd_last = (rd_cnt == 2'(RD_LAT - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        o_rf_addr  = '0;
        o_rf_wdata = '0;
        o_rf_we    = 1'b0;
        o_rf_re    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                o_rf_addr  = lat_addr;
                o_rf_wdata = lat_wdata;
                o_rf_we    = lat_wr;
                o_rf_re    = !lat_wr;
                state_nxt  = lat_wr ? DONE : WAIT_RD;
            end
            WAIT_RD: begin
                if (rd_last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_served <= PORT_B;
            lat_wr      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rd_cnt      <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            // Request lines are only looked at here; later changes cannot leak in.
            if (state == IDLE && grant_valid) begin
                last_served <= grant_port;
                lat_wr      <= (grant_port == PORT_B) ? i_b_wr    : i_a_wr;
                lat_addr    <= (grant_port == PORT_B) ? i_b_addr  : i_a_addr;
                lat_wdata   <= (grant_port == PORT_B) ? i_b_wdata : i_a_wdata;
            end
            if (state == ISSUE)        rd_cnt <= '0;
            else if (state == WAIT_RD) rd_cnt <= rd_cnt + 2'd1;
            if (state == WAIT_RD && rd_last) begin
                if (last_served == PORT_B) b_rdata_q <= i_rf_rdata;
                else                       a_rdata_q <= i_rf_rdata;
            end
        end
    end

    assign o_a_ack     = (state == DONE) && (last_served == PORT_A);
    assign o_b_ack     = (state == DONE) && (last_served == PORT_B);
    assign o_a_rdata   = a_rdata_q;
    assign o_b_rdata   = b_rdata_q;
    assign o_busy      = (state != IDLE);
    assign o_dbg_state = state;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: scoreboarded acks and register-file
// accesses, plus per-scenario checks of latency, locking and reset abort.
module tb_reg_bus_arbiter;

  localparam int RD_LAT   = 2;
  localparam int MAX_HOLD = 16;
  localparam int BOUND    = 200;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_a_req = 1'b0, i_a_wr = 1'b0, i_a_lock = 1'b0;
  logic [6:0] i_a_addr = '0;
  logic [7:0] i_a_wdata = '0;
  logic       i_b_req = 1'b0, i_b_wr = 1'b0, i_b_lock = 1'b0;
  logic [6:0] i_b_addr = '0;
  logic [7:0] i_b_wdata = '0;
  logic       o_a_ack, o_b_ack, o_rf_we, o_rf_re, o_busy, o_timeout;
  logic [7:0] o_a_rdata, o_b_rdata, o_rf_wdata, i_rf_rdata;
  logic [6:0] o_rf_addr;
  logic [1:0] o_dbg_state;

  reg_bus_arbiter #(.RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_a_req(i_a_req), .i_a_wr(i_a_wr), .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata), .i_a_lock(i_a_lock),
    .i_b_req(i_b_req), .i_b_wr(i_b_wr), .i_b_addr(i_b_addr), .i_b_wdata(i_b_wdata), .i_b_lock(i_b_lock),
    .o_a_ack(o_a_ack), .o_a_rdata(o_a_rdata), .o_b_ack(o_b_ack), .o_b_rdata(o_b_rdata),
    .o_rf_addr(o_rf_addr), .o_rf_wdata(o_rf_wdata), .o_rf_we(o_rf_we), .o_rf_re(o_rf_re),
    .i_rf_rdata(i_rf_rdata), .o_busy(o_busy), .o_timeout(o_timeout), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- register-file model ----------------
  // Read data is only valid on the final WAIT_RD cycle; any other cycle shows 8'hEE.
  logic [7:0] mem [0:127];
  logic [6:0] rd_addr_q;
  int         rd_age;

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rd_age <= 0;
    else if (o_rf_re) begin rd_addr_q <= o_rf_addr; rd_age <= 1; end
    else if (rd_age != 0 && rd_age < 8) rd_age <= rd_age + 1;
  end
  assign i_rf_rdata = (rd_age == RD_LAT) ? mem[rd_addr_q] : 8'hEE;

  // ---------------- scoreboard ----------------
  int          tests_run = 0, tests_failed = 0;
  logic [9:0]  exp_q[$];      // {port, is_read, rdata}
  logic [15:0] exp_rf_q[$];   // {we, addr, wdata}
  logic [7:0]  exp_rd_a = '0, exp_rd_b = '0;
  logic [9:0]  mon_e;
  logic [15:0] mon_r;
  int          ack_a_cnt = 0, ack_b_cnt = 0, timeout_cnt = 0, rf_we_cnt = 0;
  bit          mon_en = 1'b0;

  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_rf_we || o_rf_re) begin
        tests_run++;
        if (o_rf_we && o_rf_re) begin
          tests_failed++; $display("FAIL rf_strobe_both: got we=1 re=1, expected one strobe");
        end else if (exp_rf_q.size() == 0) begin
          tests_failed++; $display("FAIL rf_unexpected: got we=%0b addr=%h, expected no access", o_rf_we, o_rf_addr);
        end else begin
          mon_r = exp_rf_q.pop_front();
          if (o_rf_we !== mon_r[15] || o_rf_addr !== mon_r[14:8] || (mon_r[15] && o_rf_wdata !== mon_r[7:0])) begin
            tests_failed++;
            $display("FAIL rf_access: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                     o_rf_we, o_rf_addr, o_rf_wdata, mon_r[15], mon_r[14:8], mon_r[7:0]);
          end
        end
        if (o_rf_we) rf_we_cnt++;
      end
      if (o_a_ack || o_b_ack) begin
        tests_run++;
        if (o_a_ack && o_b_ack) begin
          tests_failed++; $display("FAIL ack_both: got a_ack=1 b_ack=1, expected one ack");
        end else if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL ack_unexpected: got ack on port %0d, expected none", o_b_ack);
        end else begin
          mon_e = exp_q.pop_front();
          if (o_b_ack !== mon_e[9]) begin
            tests_failed++; $display("FAIL ack_port: got port %0d, expected port %0d", o_b_ack, mon_e[9]);
          end else if (mon_e[8]) begin
            if (mon_e[9]) exp_rd_b = mon_e[7:0];
            else          exp_rd_a = mon_e[7:0];
          end
        end
        if (o_a_ack) ack_a_cnt++;
        if (o_b_ack) ack_b_cnt++;
      end
      tests_run++;
      if (o_a_rdata !== exp_rd_a || o_b_rdata !== exp_rd_b) begin
        tests_failed++;
        $display("FAIL rdata: got a=%h b=%h, expected a=%h b=%h", o_a_rdata, o_b_rdata, exp_rd_a, exp_rd_b);
      end
      if (o_timeout) timeout_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic port, input logic wr, input logic [6:0] addr, input logic [7:0] wdata);
    exp_q.push_back({port, ~wr, (wr ? 8'h00 : mem[addr])});
    exp_rf_q.push_back({wr, addr, wdata});
  endtask

  task automatic start_req(input logic port, input logic wr, input logic [6:0] addr,
                           input logic [7:0] wdata, input logic lock);
    if (port == 1'b0) begin
      i_a_req = 1'b1; i_a_wr = wr; i_a_addr = addr; i_a_wdata = wdata; i_a_lock = lock;
    end else begin
      i_b_req = 1'b1; i_b_wr = wr; i_b_addr = addr; i_b_wdata = wdata; i_b_lock = lock;
    end
  endtask

  task automatic drop_req(input logic port);
    if (port == 1'b0) i_a_req = 1'b0;
    else              i_b_req = 1'b0;
  endtask

  // Returns the negedge index (0 = the edge before the IDLE sample) of the ack.
  task automatic wait_ack(input logic port, output int lat);
    lat = -1;
    for (int n = 0; n < BOUND; n++) begin
      @(negedge i_clk);
      if ((port == 1'b0 && o_a_ack) || (port == 1'b1 && o_b_ack)) begin lat = n; break; end
    end
    if (lat < 0) begin
      tests_run++; tests_failed++;
      $display("FAIL ack_timeout: got no ack on port %0d, expected one within %0d cycles", port, BOUND);
    end
    @(posedge i_clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    tests_run++;
    if ({o_a_ack, o_b_ack, o_rf_we, o_rf_re, o_busy, o_timeout} !== 6'b0 ||
        {o_rf_addr, o_rf_wdata, o_a_rdata, o_b_rdata} !== 31'h0 || o_dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got acks=%b%b strobes=%b%b busy=%b to=%b addr=%h wd=%h rda=%h rdb=%h st=%0d, expected all 0",
               o_a_ack, o_b_ack, o_rf_we, o_rf_re, o_busy, o_timeout, o_rf_addr, o_rf_wdata, o_a_rdata, o_b_rdata, o_dbg_state);
    end
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_write();
    int lat, we0;
    we0 = rf_we_cnt;
    push_exp(1'b0, 1'b1, 7'h12, 8'hA5);
    start_req(1'b0, 1'b1, 7'h12, 8'hA5, 1'b0);
    wait_ack(1'b0, lat);
    drop_req(1'b0);
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL write_latency: got %0d, expected 2", lat); end
    tests_run++;
    if (rf_we_cnt - we0 !== 1) begin tests_failed++; $display("FAIL write_strobe_cycles: got %0d, expected 1", rf_we_cnt - we0); end
  endtask

  task automatic test_read();
    int lat;
    push_exp(1'b1, 1'b0, 7'h05, 8'h00);
    start_req(1'b1, 1'b0, 7'h05, 8'h00, 1'b0);
    wait_ack(1'b1, lat);
    drop_req(1'b1);
    tests_run++;
    if (lat !== 2 + RD_LAT) begin tests_failed++; $display("FAIL read_latency: got %0d, expected %0d", lat, 2 + RD_LAT); end
    push_exp(1'b1, 1'b1, 7'h06, 8'h11);
    start_req(1'b1, 1'b1, 7'h06, 8'h11, 1'b0);
    wait_ack(1'b1, lat);
    drop_req(1'b1);
    tests_run++;
    if (o_b_rdata !== 8'h3C) begin tests_failed++; $display("FAIL read_hold: got %h, expected 3c", o_b_rdata); end
  endtask

  task automatic test_in_flight();
    int lat;
    push_exp(1'b0, 1'b1, 7'h33, 8'h77);
    start_req(1'b0, 1'b1, 7'h33, 8'h77, 1'b0);
    @(posedge i_clk); #1;
    i_a_wr = 1'b0; i_a_addr = 7'h7F; i_a_wdata = 8'h00;
    wait_ack(1'b0, lat);
    drop_req(1'b0);
  endtask

  task automatic test_random();
    int lat;
    logic p, w;
    logic [6:0] ad;
    logic [7:0] wd;
    for (int k = 0; k < 8; k++) begin
      p = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
      ad = 7'($urandom_range(0, 127)); wd = 8'($urandom_range(0, 255));
      push_exp(p, w, ad, wd);
      start_req(p, w, ad, wd, 1'b0);
      wait_ack(p, lat);
      drop_req(p);
      tests_run++;
      if (lat !== (w ? 2 : 2 + RD_LAT)) begin
        tests_failed++; $display("FAIL random_latency: got %0d, expected %0d (wr=%0b)", lat, (w ? 2 : 2 + RD_LAT), w);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic hit;
    int a0;
    exp_rf_q.push_back({1'b0, 7'h09, 8'h00});
    start_req(1'b0, 1'b0, 7'h09, 8'h00, 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge i_clk);
      if (o_dbg_state == 2'd2) begin hit = 1'b1; break; end
    end
    tests_run++;
    if (!hit) begin tests_failed++; $display("FAIL reach_wait_rd: got no WAIT_RD state, expected one"); end
    #2;
    i_reset_n = 1'b0; drop_req(1'b0);
    exp_rd_a = '0; exp_rd_b = '0;
    #1;
    tests_run++;
    if ({o_rf_re, o_rf_we, o_busy, o_a_ack} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_abort: got re=%b we=%b busy=%b ack=%b, expected 0000", o_rf_re, o_rf_we, o_busy, o_a_ack);
    end
    tests_run++;
    if (exp_rf_q.size() != 0) begin tests_failed++; $display("FAIL abort_issue: got %0d pending accesses, expected 0", exp_rf_q.size()); end
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    a0 = ack_a_cnt;
    repeat (4) @(negedge i_clk);
    tests_run++;
    if (ack_a_cnt !== a0) begin tests_failed++; $display("FAIL abort_no_ack: got %0d acks, expected 0", ack_a_cnt - a0); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_contention();
    int la, lb;
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b0, 1'b1, 7'(64 + k), 8'(192 + k));
      push_exp(1'b1, 1'b0, 7'(72 + k), 8'h00);
    end
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          start_req(1'b0, 1'b1, 7'(64 + k), 8'(192 + k), 1'b0);
          wait_ack(1'b0, la);
        end
        drop_req(1'b0);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          start_req(1'b1, 1'b0, 7'(72 + k), 8'h00, 1'b0);
          wait_ack(1'b1, lb);
        end
        drop_req(1'b1);
      end
    join
  endtask

  task automatic test_lock();
    int la, lb, b0;
    for (int k = 0; k < 4; k++) push_exp(1'b0, 1'b1, 7'(32 + k), 8'(80 + k));
    push_exp(1'b1, 1'b0, 7'h22, 8'h00);
    b0 = ack_b_cnt;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          start_req(1'b0, 1'b1, 7'(32 + k), 8'(80 + k), 1'b1);
          wait_ack(1'b0, la);
        end
        tests_run++;
        if (ack_b_cnt !== b0) begin tests_failed++; $display("FAIL lock_held: got %0d B acks, expected 0", ack_b_cnt - b0); end
        drop_req(1'b0); i_a_lock = 1'b0;
      end
      begin
        start_req(1'b1, 1'b0, 7'h22, 8'h00, 1'b0);
        wait_ack(1'b1, lb);
        drop_req(1'b1);
      end
    join
  endtask

  task automatic test_hold_timeout();
    int lat, t0, a0, b0;
    t0 = timeout_cnt;
    b0 = ack_b_cnt;
    start_req(1'b1, 1'b1, 7'h44, 8'h99, 1'b0);
`ifdef REG_ARB_HOLD_TIMEOUT_EN
    for (int k = 0; k < 40 && timeout_cnt == t0; k++) begin
      push_exp(1'b0, 1'b1, 7'(96 + k), 8'(k));
      start_req(1'b0, 1'b1, 7'(96 + k), 8'(k), 1'b1);
      wait_ack(1'b0, lat);
    end
    tests_run++;
    if (timeout_cnt - t0 !== 1) begin tests_failed++; $display("FAIL timeout_pulse: got %0d cycles, expected 1", timeout_cnt - t0); end
    push_exp(1'b1, 1'b1, 7'h44, 8'h99);
    push_exp(1'b0, 1'b1, i_a_addr, i_a_wdata);
    a0 = ack_a_cnt;
    wait_ack(1'b1, lat);
    drop_req(1'b1);
    tests_run++;
    if (ack_a_cnt !== a0) begin tests_failed++; $display("FAIL timeout_grant_b: got %0d A acks first, expected 0", ack_a_cnt - a0); end
    wait_ack(1'b0, lat);
    drop_req(1'b0); i_a_lock = 1'b0;
`else
    for (int k = 0; k < 10; k++) begin
      push_exp(1'b0, 1'b1, 7'(96 + k), 8'(k));
      start_req(1'b0, 1'b1, 7'(96 + k), 8'(k), 1'b1);
      wait_ack(1'b0, lat);
    end
    drop_req(1'b0); i_a_lock = 1'b0;
    tests_run++;
    if (ack_b_cnt !== b0) begin tests_failed++; $display("FAIL lock_starve: got %0d B acks, expected 0", ack_b_cnt - b0); end
    tests_run++;
    if (timeout_cnt !== t0) begin tests_failed++; $display("FAIL timeout_tied: got %0d pulses, expected 0", timeout_cnt - t0); end
    push_exp(1'b1, 1'b1, 7'h44, 8'h99);
    wait_ack(1'b1, lat);
    drop_req(1'b1);
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom_range(0, 237));
    mem[5] = 8'h3C;
    test_reset();
    test_write();
    test_read();
    test_in_flight();
    test_random();
    test_reset_mid_read();
    test_contention();
    test_lock();
    test_hold_timeout();
    repeat (4) @(negedge i_clk);
    tests_run++;
    if (exp_q.size() != 0 || exp_rf_q.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: got %0d acks and %0d accesses pending, expected 0", exp_q.size(), exp_rf_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, register-file read latency in cycles (legal 1..3).
REQ-002 Parameter MAX_HOLD, default 255, maximum cycles a locked grant may be retained (legal 1..255).
REQ-003 Clock and reset: one clock, i_clk; reset i_reset_n is asynchronous and active-low.
REQ-004 i_clk  in  1  system clock.
REQ-005 i_reset_n  in  1  asynchronous active-low reset.
REQ-006 i_a_req / i_b_req  in  1  level transaction request, port A (SPI host) / port B (internal engine).
REQ-007 i_a_wr / i_b_wr  in  1  1 = write, 0 = read.
REQ-008 i_a_addr / i_b_addr  in  7  register address.
REQ-009 i_a_wdata / i_b_wdata  in  8  write data.
REQ-010 i_a_lock / i_b_lock  in  1  retain grant across consecutive transactions.
REQ-011 o_a_ack / o_b_ack  out  1  one-cycle transaction-complete pulse.
REQ-012 o_a_rdata / o_b_rdata  out  8  read data, valid with ack, held until that port's next ack.
REQ-013 o_rf_addr  out  7; o_rf_wdata  out  8; o_rf_we  out  1; o_rf_re  out  1; i_rf_rdata  in  8: register-file side.
REQ-014 o_busy  out  1  state != IDLE; o_timeout  out  1  one-cycle pulse on forced lock release.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_RD, DONE.
REQ-016 IDLE: if no eligible request, stay; else latch winner's wr/addr/wdata, go to ISSUE.
REQ-017 Arbitration: single requester wins; both requesting -> port not served last wins (round-robin); after reset port A wins first.
REQ-018 Lock: while owner (last served port) holds lock high and has not timed out, only owner is eligible; other port waits indefinitely.
REQ-019 ISSUE (exactly 1 cycle): o_rf_addr/o_rf_wdata = latched values; o_rf_we = wr, o_rf_re = !wr; write -> DONE, read -> WAIT_RD.
REQ-020 WAIT_RD: lasts RD_LAT cycles; i_rf_rdata captured on last cycle, then DONE.
REQ-021 DONE (1 cycle): ack of served port = 1, rdata updated only for reads; -> IDLE.
REQ-022 Latency req-seen-in-IDLE to ack: write 2 cycles, read 2+RD_LAT cycles; min spacing between accesses: write 3, read 3+RD_LAT.
REQ-023 Requester holds req/wr/addr/wdata stable until ack; drop req in the cycle after ack or keep high for back-to-back.
REQ-024 o_rf_we/o_rf_re SHALL be 0 in every state except ISSUE; never both 1.
REQ-025 Request changes outside IDLE SHALL not affect the transaction in flight.

Reset
REQ-026 Asynchronous reset: state IDLE, last-served = B, all outputs 0, rdata registers 8'h00, hold counter 0.
REQ-027 Reset mid-transaction aborts immediately; no ack, no further rf strobe emitted.

Configuration
REQ-028 Macro REG_ARB_HOLD_TIMEOUT_EN defined: hold counter increments each cycle lock is honoured with the other port requesting; at MAX_HOLD, o_timeout pulses, lock of owner ignored until owner deasserts lock, counter clears.
REQ-029 Macro undefined: no counter, lock honoured indefinitely, o_timeout tied 0.

Structure
REQ-030 Shared package/include reg_arb_pkg: FSM state encodings, port IDs (PORT_A = 0, PORT_B = 1), address/data width constants (7, 8).
REQ-031 One sub-module reg_arb_hold_timer (8-bit hold counter, expiry flag), instantiated only with REG_ARB_HOLD_TIMEOUT_EN.

Verification
REQ-032 A write addr 7'h12 data 8'hA5 alone -> o_rf_we 1 cycle with 7'h12/8'hA5, o_a_ack 2 cycles after IDLE sample.
REQ-033 B read 7'h05, RD_LAT=2, i_rf_rdata 8'h3C -> o_b_ack at cycle 4, o_b_rdata 8'h3C held until next B ack.
REQ-034 A and B request same cycle after reset, no lock -> A served first, B next; repeat pair -> alternates.
REQ-035 A lock high with 4 back-to-back writes, B requesting -> all 4 A writes before B; B served after lock drops.
REQ-036 REG_ARB_HOLD_TIMEOUT_EN, MAX_HOLD=4, A lock stuck high, B requesting -> o_timeout pulse, B granted next; without macro B starves.
REQ-037 Reset asserted during WAIT_RD -> no ack, o_rf_re 0, o_busy 0; first post-reset contention grants A.
